// File: rtl/load_store_unit.sv
// Load/store unit bridging the execute stage to a one-cycle registered-read memory port.
// Handles byte/halfword/word accesses with lane steering, extension and alignment faults.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [3:0]            mem_byte_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_q, state_d;
  logic we_q, we_d;
  logic [1:0] off_q, off_d;
  logic [2:0] f3_q, f3_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_fault_q, resp_fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic mem_wr_en_q, mem_wr_en_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic [3:0] mem_byte_en_q, mem_byte_en_d;

  logic [1:0] sz;
  logic misal, illegal, fault;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] ld;

  always_comb begin
    sz = req_funct3[1:0];
    misal = (sz == 2'b01 && req_addr[0]) ||
            (sz == 2'b10 && req_addr[1:0] != 2'b00);
    if (req_we) illegal = req_funct3[2] || sz == 2'b11;
    else        illegal = sz == 2'b11 || req_funct3 == 3'b110;
    fault = misal || illegal;
  end

  // Lane selection uses the offset captured at acceptance
  always_comb begin
    lb = 8'(mem_rd_data >> {off_q, 3'b000});
    lh = off_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (f3_q)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b100:  ld = {24'd0, lb};
      3'b101:  ld = {16'd0, lh};
      default: ld = mem_rd_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    off_d         = off_q;
    f3_d          = f3_q;
    resp_valid_d  = 1'b0;
    resp_fault_d  = resp_fault_q;
    resp_rdata_d  = resp_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_data_d = mem_wr_data_q;
    mem_byte_en_d = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            we_d       = req_we;
            off_d      = req_addr[1:0];
            f3_d       = req_funct3;
            mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            state_d    = ISSUE;
            if (req_we) begin
              mem_wr_en_d = 1'b1;
              case (sz)
                2'b00: begin
                  mem_byte_en_d = 4'b0001 << req_addr[1:0];
                  mem_wr_data_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                  mem_byte_en_d = req_addr[1] ? 4'b1100 : 4'b0011;
                  mem_wr_data_d = {2{req_wdata[15:0]}};
                end
                default: begin
                  mem_byte_en_d = 4'b1111;
                  mem_wr_data_d = req_wdata;
                end
              endcase
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = 32'd0;
          state_d      = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = ld;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= 32'd0;
      mem_byte_en_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      resp_valid_q  <= resp_valid_d;
      resp_fault_q  <= resp_fault_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_byte_en_q <= mem_byte_en_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_fault  = resp_fault_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_byte_en = mem_byte_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses against a
// byte-addressed reference memory, with a registered-read memory attached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [16];
  logic [7:0]  refm [64];
  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_byte_en(mem_byte_en), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i])
          mem[mem_addr[5:2]][8*i +: 8] <= mem_wr_data[8*i +: 8];
    mem_rd_data <= mem[mem_addr[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_fault(input bit we, input int f3,
                                     input int addr);
    bit bad;
    int n;
    if (we) bad = (f3 > 2);
    else    bad = (f3 == 3 || f3 == 6 || f3 == 7);
    n = 1 << (f3 % 4);
    if (n == 2 && addr % 2 != 0) bad = 1;
    if (n == 4 && addr % 4 != 0) bad = 1;
    return bad;
  endfunction

  // Called at a negedge; returns at the negedge where the response shows
  task automatic do_op(input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag);
    bit f;
    int n, base, lat, exp_lat;
    bit wr_bad;
    longint v;
    logic [31:0] exp_rd, exp_be, exp_wd;
    f = model_fault(we, int'(f3), int'(addr & 32'h3f));
    n = 1 << (int'(f3) % 4);
    base = int'(addr & 32'h3f);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (longint'(refm[(base + i) % 64]) << (8 * i));
    if (f3 < 4 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
      v = v - (longint'(1) << (8 * n));
    exp_rd = (f || we) ? 32'd0 : v[31:0];
    exp_lat = f ? 1 : (we ? 2 : 3);
    exp_be = ((32'd1 << n) - 1) << (addr & 3);
    if (n == 1)      exp_wd = (wdata & 32'hff) * 32'h01010101;
    else if (n == 2) exp_wd = (wdata & 32'hffff) * 32'h00010001;
    else             exp_wd = wdata;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_funct3 = 3'($urandom);
    lat = 0;
    wr_bad = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1 && we && !f) begin
        check({tag, ".wr_en"}, 32'(mem_wr_en), 32'd1);
        check({tag, ".mem_addr"}, mem_addr, addr & ~32'd3);
        check({tag, ".byte_en"}, 32'(mem_byte_en), exp_be);
        check({tag, ".wr_data"}, mem_wr_data, exp_wd);
      end else if (mem_wr_en) begin
        wr_bad = 1;
      end
      if (resp_valid) lat = k;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".fault"}, 32'(resp_fault), 32'(f));
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".no_stray_wr"}, 32'(wr_bad), 32'd0);
    if (we && !f)
      for (int i = 0; i < n; i++)
        refm[(base + i) % 64] = 8'(wdata >> (8 * i));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_funct3 = 3'd0;
    for (int i = 0; i < 64; i++) refm[i] = 8'd0;
    #2;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.fault", 32'(resp_fault), 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.wr_en", 32'(mem_wr_en), 32'd0);
    check("rst.wr_data", mem_wr_data, 32'd0);
    check("rst.byte_en", 32'(mem_byte_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 16; w++)
      do_op(1'b1, 3'd2, 32'h100 + 32'(4 * w), $urandom, "fill");

    do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, "sw");
    do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, "sb");
    do_op(1'b0, 3'd0, 32'h103, 32'd0, "lb");
    do_op(1'b0, 3'd4, 32'h103, 32'd0, "lbu");
    do_op(1'b1, 3'd2, 32'h100, 32'h80011234, "sw2");
    do_op(1'b0, 3'd1, 32'h102, 32'd0, "lh");
    do_op(1'b0, 3'd5, 32'h102, 32'd0, "lhu");
    do_op(1'b0, 3'd2, 32'h100, 32'd0, "lw");
    do_op(1'b0, 3'd2, 32'h101, 32'd0, "f_lw");
    do_op(1'b1, 3'd1, 32'h003, 32'h1234, "f_sh");
    do_op(1'b0, 3'd3, 32'h100, 32'd0, "f_ld3");

    for (int r = 0; r < 80; r++)
      do_op(1'($urandom), 3'($urandom),
            ($urandom & ~32'h3f) | 32'($urandom_range(0, 63)),
            $urandom, "rand");

    // Reset while a store is in ISSUE must drop the write
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h108;
    req_wdata = ~{refm[11], refm[10], refm[9], refm[8]};
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid.wr_en_before", 32'(mem_wr_en), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rstmid.wr_en", 32'(mem_wr_en), 32'd0);
    check("rstmid.byte_en", 32'(mem_byte_en), 32'd0);
    check("rstmid.wr_data", mem_wr_data, 32'd0);
    check("rstmid.mem_addr", mem_addr, 32'd0);
    check("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid.rdata", resp_rdata, 32'd0);
    check("rstmid.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid.no_resp", 32'(resp_valid), 32'd0);
    end
    do_op(1'b0, 3'd2, 32'h108, 32'd0, "rstmid.lw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the CPU execute stage and data port B of the instruction/data memory. It accepts one RISC-V load or store per handshake and, for stores, drives the memory's address, write-enable, lane-replicated write data and byte enables. For loads, it waits out the memory's one-cycle registered read, then extracts and sign- or zero-extends the addressed byte, halfword or word. Misaligned or illegal accesses are rejected with a fault response and never reach memory.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal access; qualified by resp_valid.
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0.
- mem_wr_en  out  1  memory write enable.
- mem_wr_data  out  32  lane-replicated store data.
- mem_byte_en  out  4  byte lane enables.
- mem_rd_data  in  32  memory read data, valid one cycle after the address is presented.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Handshake occurs when req_valid && req_ready.
  - On handshake, capture req_we, req_addr, req_wdata and req_funct3 into registers. Inputs are ignored at all other times.
- Fault check, applied at acceptance:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 00.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 with bit 2 set, or equal to 011.
  - On fault: stay in IDLE and register resp_valid=1, resp_fault=1, resp_rdata=0 for the next cycle. No memory access is made.
- Legal request: go to ISSUE and register the memory-side outputs.
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - SB: mem_byte_en = 1 << addr[1:0]; mem_wr_data = {4{wdata[7:0]}}.
  - SH: mem_byte_en = addr[1] ? 1100 : 0011; mem_wr_data = {2{wdata[15:0]}}.
  - SW: mem_byte_en = 1111; mem_wr_data = wdata.
  - Loads: mem_byte_en = 0000, mem_wr_en = 0.
- ISSUE:
  - Stores drive mem_wr_en=1 for exactly this cycle, then return to IDLE with resp_valid=1, resp_fault=0, resp_rdata=0.
  - Loads go to WAIT.
- WAIT:
  - Select the byte lane from mem_rd_data using captured addr[1:0]; for halfwords, select by addr[1].
  - Sign-extend for LB and LH; zero-extend for LBU and LHU; LW passes the word through.
  - Register the result into resp_rdata and set resp_valid=1. Return to IDLE.
- Outside ISSUE, mem_wr_en=0 and mem_byte_en=0000. mem_addr holds its last value.
- resp_rdata and resp_fault hold their values until the next response. resp_valid is high for one cycle only.

## Timing

- Request accepted in cycle N (IDLE).
- Load: memory outputs driven in N+1; mem_rd_data sampled in N+2; resp_valid high in N+3, during which req_ready is already 1.
- Store: mem_wr_en high in N+1; resp_valid high in N+2.
- Fault: resp_valid high in N+1; req_ready stays 1.
- Peak throughput:
  - Back-to-back loads: one per 3 cycles.
  - Back-to-back stores: one per 2 cycles.
  - Faults: one per cycle.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0, mem_byte_en=0.
- Reset mid-operation:
  - All outputs clear asynchronously and any in-flight op is dropped with no response.
  - A store in ISSUE is not committed unless mem_wr_en was sampled high before rst rose.
- Because response and acceptance occur in the same cycle, a new request accepted during a resp_valid cycle is legal.

## Test plan

- Reset: assert rst mid-cycle → all outputs 0 immediately; req_ready=1 after release.
- SW addr 0x100, data 0xDEADBEEF in cycle N → in N+1, mem_wr_en=1, mem_addr=0x100, mem_byte_en=1111, mem_wr_data=0xDEADBEEF; in N+2, resp_valid=1, resp_fault=0.
- Byte store and loads at 0x103:
  - SB addr 0x103, data 0x000000A5 → mem_byte_en=1000, mem_wr_data=0xA5A5A5A5.
  - Then LB 0x103 with memory word 0xA5000000 → resp_rdata=0xFFFFFFA5 at N+3.
  - Then LBU 0x103 → resp_rdata=0x000000A5.
- Halfword loads at 0x102, memory word 0x80011234:
  - LH → resp_rdata=0xFFFF8001.
  - LHU → resp_rdata=0x00008001.
  - LW 0x100 → resp_rdata=0x80011234.
- Faults:
  - LW 0x101 → resp_valid at N+1, resp_fault=1, resp_rdata=0.
  - SH 0x003 → same response.
  - Load funct3=011 → same response.
  - In all three cases mem_wr_en is never asserted.
- Reset during store ISSUE: assert rst while mem_wr_en=1 → mem_wr_en drops immediately, no resp_valid; after release, the next LW returns the pre-store memory word.
